exp_mu_scheduler: RTL and testbench

EXP_MU_SCHEDULER -- requirements
Module: exp_mu_scheduler

---
 rtl/exp_mu_scheduler.sv | 167 ++++++++++++++++
 tb/tb_exp_mu_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_mu_scheduler.sv
// Two-requester job scheduler for a shared exp-mu table engine: holds one job per
// requester, grants round-robin, launches the engine and forwards its results to RAM.
module exp_mu_scheduler #(
  parameter int NWORDS  = 512,
  parameter int TIMEOUT = 4096
) (
  input  logic        CLK,
  input  logic        iRst_n,
  input  logic [17:0] iMu0,
  input  logic [17:0] iS0,
  input  logic [17:0] iMu1,
  input  logic [17:0] iS1,
  input  logic        iReq0,
  input  logic        iReq1,
  output logic        oReady0,
  output logic        oReady1,
  output logic        oDone0,
  output logic        oDone1,
  output logic        oErr0,
  output logic        oErr1,
  output logic [17:0] oMu,
  output logic [17:0] oS,
  output logic        oStart,
  input  logic [17:0] iEngData,
  input  logic [8:0]  iEngAddr,
  input  logic        iEngValid,
  input  logic        iEngDone,
  output logic        oWrEn,
  output logic [9:0]  oWrAddr,
  output logic [17:0] oWrData,
  output logic        oBusy,
  output logic        oOwner
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  state_t        r_state;
  logic          r_pend0, r_pend1;
  logic [17:0]   r_mu0, r_s0, r_mu1, r_s1;
  logic          r_rr;
  logic [9:0]    r_cnt;
  logic [CW-1:0] r_cyc;

  logic          w_acc0, w_acc1;
  logic          w_fin0, w_fin1;
  logic          w_any;
  logic          w_grant;
  logic [9:0]    w_cnt_next;
  logic          w_timeout;
  logic          w_words_ok;

  assign oReady0 = ~r_pend0;
  assign oReady1 = ~r_pend1;

  assign w_acc0 = iReq0 & ~r_pend0;
  assign w_acc1 = iReq1 & ~r_pend1;
  assign w_fin0 = (r_state == FINISH) & ~oOwner;
  assign w_fin1 = (r_state == FINISH) &  oOwner;

  // With both pending the pointer decides; otherwise the lone pending requester wins.
  assign w_any   = r_pend0 | r_pend1;
  assign w_grant = (r_pend0 & r_pend1) ? r_rr : r_pend1;

  // Word count saturates so an over-long run can never wrap back onto NWORDS.
  assign w_cnt_next = (iEngValid && r_cnt != 10'h3FF) ? r_cnt + 10'd1 : r_cnt;
  assign w_timeout  = (r_cyc == CW'(TIMEOUT - 1));
  assign w_words_ok = (w_cnt_next == 10'(NWORDS));

  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
    end else begin
      if (w_acc0)      r_pend0 <= 1'b1;
      else if (w_fin0) r_pend0 <= 1'b0;
      if (w_acc1)      r_pend1 <= 1'b1;
      else if (w_fin1) r_pend1 <= 1'b0;
    end
  end

  // NOTE: job payload is never read unless its pending bit is set, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (w_acc0) begin
      r_mu0 <= iMu0;
      r_s0  <= iS0;
    end
    if (w_acc1) begin
      r_mu1 <= iMu1;
      r_s1  <= iS1;
    end
  end

  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_cyc   <= '0;
      oStart  <= 1'b0;
      oBusy   <= 1'b0;
      oOwner  <= 1'b0;
      oMu     <= '0;
      oS      <= '0;
      oWrEn   <= 1'b0;
      oWrAddr <= '0;
      oWrData <= '0;
      oDone0  <= 1'b0;
      oDone1  <= 1'b0;
      oErr0   <= 1'b0;
      oErr1   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here with non-blocking writes; a later
      // assignment in the case below overrides the default for that cycle only.
      oStart <= 1'b0;
      oWrEn  <= 1'b0;
      oDone0 <= 1'b0;
      oDone1 <= 1'b0;
      oErr0  <= 1'b0;
      oErr1  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            oOwner  <= w_grant;
            oMu     <= w_grant ? r_mu1 : r_mu0;
            oS      <= w_grant ? r_s1  : r_s0;
            r_rr    <= ~w_grant;
            oStart  <= 1'b1;
            oBusy   <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_cyc   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (iEngValid) begin
            oWrEn   <= 1'b1;
            oWrAddr <= {oOwner, iEngAddr};
            oWrData <= iEngData;
            r_cnt   <= w_cnt_next;
          end
          r_cyc <= r_cyc + 1'b1;
          if (iEngDone || w_timeout) begin
            r_state <= FINISH;
            if (iEngDone && w_words_ok) begin
              if (oOwner) oDone1 <= 1'b1;
              else        oDone0 <= 1'b1;
            end else begin
              if (oOwner) oErr1 <= 1'b1;
              else        oErr0 <= 1'b1;
            end
          end
        end
        FINISH: begin
          oBusy   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_mu_scheduler.sv
// Directed bench for exp_mu_scheduler: a simple engine model drives result streams and
// a negedge monitor logs starts, writes and completion pulses for the scenario tasks.
module tb_exp_mu_scheduler;

  localparam int NW = 512;
  localparam int TO = 4096;

  logic        CLK = 1'b0;
  logic        iRst_n = 1'b1;
  logic [17:0] iMu0 = '0, iS0 = '0, iMu1 = '0, iS1 = '0;
  logic        iReq0 = 1'b0, iReq1 = 1'b0;
  logic        oReady0, oReady1, oDone0, oDone1, oErr0, oErr1;
  logic [17:0] oMu, oS;
  logic        oStart;
  logic [17:0] iEngData = '0;
  logic [8:0]  iEngAddr = '0;
  logic        iEngValid = 1'b0, iEngDone = 1'b0;
  logic        oWrEn;
  logic [9:0]  oWrAddr;
  logic [17:0] oWrData;
  logic        oBusy, oOwner;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state: writes must walk {owner, 0,1,2,...} within each job.
  int job_wr = 0;
  int wr_total = 0;
  int wr_bad = 0;
  int start_log[$];
  int evt_log[$];   // 0 done0, 1 done1, 2 err0, 3 err1

  exp_mu_scheduler #(.NWORDS(NW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .iRst_n(iRst_n),
    .iMu0(iMu0), .iS0(iS0), .iMu1(iMu1), .iS1(iS1),
    .iReq0(iReq0), .iReq1(iReq1),
    .oReady0(oReady0), .oReady1(oReady1),
    .oDone0(oDone0), .oDone1(oDone1), .oErr0(oErr0), .oErr1(oErr1),
    .oMu(oMu), .oS(oS), .oStart(oStart),
    .iEngData(iEngData), .iEngAddr(iEngAddr), .iEngValid(iEngValid), .iEngDone(iEngDone),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oBusy(oBusy), .oOwner(oOwner)
  );

  always #5 CLK = ~CLK;

  function automatic logic [17:0] edata(input int i);
    return 18'(i * 37 + 5);
  endfunction

  always @(negedge CLK) begin
    if (iRst_n) begin
      if (oStart) begin
        job_wr = 0;
        start_log.push_back(int'(oOwner));
      end
      if (oWrEn) begin
        if (oWrAddr !== {oOwner, 9'(job_wr)} || oWrData !== edata(job_wr)) wr_bad++;
        job_wr++;
        wr_total++;
      end
      if (oDone0) evt_log.push_back(0);
      if (oDone1) evt_log.push_back(1);
      if (oErr0)  evt_log.push_back(2);
      if (oErr1)  evt_log.push_back(3);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    iRst_n = 1'b0;
    step();
    iRst_n = 1'b1;
    step();
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      step();
      ok = (oStart === 1'b1);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_start: oStart never seen within 64 cycles, expected 1");
    end
  endtask

  // Engine model: n result words at addresses 0..n-1, optional done with the last word.
  task automatic run_words(input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      iEngValid = 1'b1;
      iEngAddr  = 9'(i);
      iEngData  = edata(i);
      iEngDone  = with_done && (i == n - 1);
      step();
    end
    iEngValid = 1'b0;
    iEngDone  = 1'b0;
    iEngAddr  = '0;
    iEngData  = '0;
  endtask

  task automatic test_reset();
    #2 iRst_n = 1'b0;
    #1;
    vectors++;
    if ({oStart, oWrEn, oDone0, oDone1, oErr0, oErr1, oBusy, oOwner, oMu, oS, oWrAddr, oWrData} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got start=%b wren=%b busy=%b owner=%b mu=%0d s=%0d addr=%0d data=%0d, expected all 0",
               oStart, oWrEn, oBusy, oOwner, oMu, oS, oWrAddr, oWrData);
    end
    vectors++;
    if ({oReady0, oReady1} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, expected 11", {oReady0, oReady1});
    end
    step();
    iRst_n = 1'b1;
    step();
  endtask

  task automatic test_single_job();
    int s_wr, s_bad, s_evt, s_st;
    do_reset();
    s_wr = wr_total; s_bad = wr_bad; s_evt = evt_log.size(); s_st = start_log.size();
    iMu0 = 18'd184; iS0 = 18'd24576; iReq0 = 1'b1;
    step();
    iReq0 = 1'b0; iMu0 = 18'd999; iS0 = 18'd1;
    vectors++;
    if ({oReady0, oStart} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_accept: got ready0=%b start=%b, expected 0 0", oReady0, oStart);
    end
    step();
    vectors++;
    if ({oStart, oBusy, oOwner} !== 3'b110) begin
      miscompares++;
      $display("FAIL single_start_latency: got start=%b busy=%b owner=%b, expected 1 1 0", oStart, oBusy, oOwner);
    end
    vectors++;
    if (oMu !== 18'd184 || oS !== 18'd24576) begin
      miscompares++;
      $display("FAIL single_params: got mu=%0d s=%0d, expected 184 24576", oMu, oS);
    end
    step();
    run_words(NW, 1'b1);
    vectors++;
    if ({oDone0, oErr0, oBusy} !== 3'b101 || oMu !== 18'd184) begin
      miscompares++;
      $display("FAIL single_finish: got done0=%b err0=%b busy=%b mu=%0d, expected 1 0 1 184", oDone0, oErr0, oBusy, oMu);
    end
    step();
    vectors++;
    if ({oBusy, oReady0} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b ready0=%b, expected 0 1", oBusy, oReady0);
    end
    step();
    vectors++;
    if (wr_total - s_wr != NW || wr_bad != s_bad) begin
      miscompares++;
      $display("FAIL single_writes: got %0d writes (%0d bad), expected %0d (0 bad)", wr_total - s_wr, wr_bad - s_bad, NW);
    end
    vectors++;
    if (evt_log.size() != s_evt + 1 || evt_log[s_evt] != 0 || start_log.size() != s_st + 1) begin
      miscompares++;
      $display("FAIL single_events: got %0d events %0d starts, expected one done0 and one start",
               evt_log.size() - s_evt, start_log.size() - s_st);
    end
  endtask

  task automatic test_contention();
    int s_wr, s_bad, s_evt;
    bit ok;
    do_reset();
    s_wr = wr_total; s_bad = wr_bad; s_evt = evt_log.size();
    iMu0 = 18'd100; iS0 = 18'd200; iMu1 = 18'd300; iS1 = 18'd400;
    iReq0 = 1'b1; iReq1 = 1'b1;
    step();
    iReq0 = 1'b0; iReq1 = 1'b0;
    vectors++;
    if ({oReady0, oReady1} !== 2'b00) begin
      miscompares++;
      $display("FAIL contention_accept: got ready=%b, expected 00", {oReady0, oReady1});
    end
    wait_start(ok);
    vectors++;
    if (oOwner !== 1'b0 || oMu !== 18'd100) begin
      miscompares++;
      $display("FAIL contention_first: got owner=%b mu=%0d, expected 0 100", oOwner, oMu);
    end
    step();
    run_words(NW, 1'b1);
    wait_start(ok);
    vectors++;
    if (oOwner !== 1'b1 || oMu !== 18'd300 || oS !== 18'd400) begin
      miscompares++;
      $display("FAIL contention_second: got owner=%b mu=%0d s=%0d, expected 1 300 400", oOwner, oMu, oS);
    end
    step();
    run_words(NW, 1'b1);
    step();
    step();
    vectors++;
    if (wr_total - s_wr != 2 * NW || wr_bad != s_bad) begin
      miscompares++;
      $display("FAIL contention_writes: got %0d writes (%0d bad), expected %0d (0 bad)", wr_total - s_wr, wr_bad - s_bad, 2 * NW);
    end
    vectors++;
    if (evt_log.size() != s_evt + 2 || evt_log[s_evt] != 0 || evt_log[s_evt + 1] != 1) begin
      miscompares++;
      $display("FAIL contention_order: got %0d events, expected done0 then done1", evt_log.size() - s_evt);
    end
  endtask

  task automatic test_fairness();
    int s_st;
    bit ok;
    do_reset();
    s_st = start_log.size();
    iMu0 = 18'd11; iMu1 = 18'd22;
    iReq0 = 1'b1;
    wait_start(ok);
    iReq1 = 1'b1;
    step();
    iReq1 = 1'b0;
    vectors++;
    if ({oReady0, oReady1} !== 2'b00) begin
      miscompares++;
      $display("FAIL fairness_pending: got ready=%b, expected 00", {oReady0, oReady1});
    end
    run_words(NW, 1'b1);
    wait_start(ok);
    vectors++;
    if (oOwner !== 1'b1 || oMu !== 18'd22) begin
      miscompares++;
      $display("FAIL fairness_second: got owner=%b mu=%0d, expected 1 22", oOwner, oMu);
    end
    step();
    run_words(NW, 1'b1);
    wait_start(ok);
    iReq0 = 1'b0;
    step();
    run_words(NW, 1'b1);
    step();
    step();
    vectors++;
    if (start_log.size() != s_st + 3 || start_log[s_st] != 0 || start_log[s_st + 1] != 1 || start_log[s_st + 2] != 0) begin
      miscompares++;
      $display("FAIL fairness_order: got %0d grants, expected order 0,1,0", start_log.size() - s_st);
    end
  endtask

  task automatic test_short_run();
    int s_wr, s_evt;
    bit ok;
    do_reset();
    s_wr = wr_total; s_evt = evt_log.size();
    iMu0 = 18'd5; iReq0 = 1'b1;
    wait_start(ok);
    iReq0 = 1'b0;
    step();
    run_words(500, 1'b1);
    vectors++;
    if ({oDone0, oErr0} !== 2'b01) begin
      miscompares++;
      $display("FAIL short_finish: got done0=%b err0=%b, expected 0 1", oDone0, oErr0);
    end
    step();
    vectors++;
    if ({oReady0, oBusy} !== 2'b10) begin
      miscompares++;
      $display("FAIL short_idle: got ready0=%b busy=%b, expected 1 0", oReady0, oBusy);
    end
    step();
    vectors++;
    if (wr_total - s_wr != 500 || evt_log.size() != s_evt + 1 || evt_log[s_evt] != 2) begin
      miscompares++;
      $display("FAIL short_events: got %0d writes %0d events, expected 500 writes and one err0", wr_total - s_wr, evt_log.size() - s_evt);
    end
  endtask

  task automatic test_hung_engine();
    int s_wr, s_evt, s_st, n;
    bit ok;
    do_reset();
    s_wr = wr_total; s_evt = evt_log.size();
    iReq0 = 1'b1;
    wait_start(ok);
    iReq0 = 1'b0;
    n = 0;
    step();
    n++;
    run_words(10, 1'b0);
    n += 10;
    while (oErr0 !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    // LAUNCH is sample 0, so FINISH appears after LAUNCH plus TO RUN cycles.
    vectors++;
    if (oErr0 !== 1'b1 || oDone0 !== 1'b0 || n != TO + 1) begin
      miscompares++;
      $display("FAIL hung_timeout: got err0=%b done0=%b after %0d cycles, expected err0 after %0d", oErr0, oDone0, n, TO + 1);
    end
    step();
    s_st = start_log.size();
    iEngValid = 1'b1; iEngDone = 1'b1; iEngAddr = 9'd5; iEngData = 18'd77;
    for (int i = 0; i < 8; i++) step();
    iEngValid = 1'b0; iEngDone = 1'b0;
    step();
    vectors++;
    if (oBusy !== 1'b0 || wr_total - s_wr != 10 || start_log.size() != s_st) begin
      miscompares++;
      $display("FAIL hung_idle_ignore: got busy=%b writes=%0d starts=%0d, expected 0 10 0", oBusy, wr_total - s_wr, start_log.size() - s_st);
    end
    vectors++;
    if (evt_log.size() != s_evt + 1 || evt_log[s_evt] != 2) begin
      miscompares++;
      $display("FAIL hung_events: got %0d events, expected one err0", evt_log.size() - s_evt);
    end
  endtask

  task automatic test_reset_mid_run();
    int s_wr, s_bad, s_evt, s_st;
    bit ok;
    do_reset();
    s_wr = wr_total; s_bad = wr_bad; s_evt = evt_log.size();
    iMu1 = 18'd777; iS1 = 18'd888; iReq1 = 1'b1;
    wait_start(ok);
    iReq1 = 1'b0;
    vectors++;
    if (oOwner !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_owner: got %b, expected 1", oOwner);
    end
    step();
    run_words(100, 1'b0);
    step();
    vectors++;
    if (wr_total - s_wr != 100 || oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_prewrites: got %0d writes busy=%b, expected 100 1", wr_total - s_wr, oBusy);
    end
    iEngValid = 1'b1; iEngAddr = 9'd3; iEngData = 18'd5;
    iRst_n = 1'b0;
    #1;
    vectors++;
    if ({oStart, oWrEn, oDone0, oDone1, oErr0, oErr1, oBusy, oOwner, oMu, oS, oWrAddr, oWrData} !== '0 ||
        {oReady0, oReady1} !== 2'b11) begin
      miscompares++;
      $display("FAIL midrst_outputs: got busy=%b owner=%b mu=%0d s=%0d wren=%b ready=%b, expected all 0 and ready 11",
               oBusy, oOwner, oMu, oS, oWrEn, {oReady0, oReady1});
    end
    step();
    step();
    iRst_n = 1'b1;
    iEngDone = 1'b1;
    s_st = start_log.size();
    for (int i = 0; i < 6; i++) step();
    iEngValid = 1'b0; iEngDone = 1'b0;
    step();
    vectors++;
    if (wr_total - s_wr != 100 || evt_log.size() != s_evt || start_log.size() != s_st || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_silent: got writes=%0d events=%0d starts=%0d busy=%b, expected 100 0 0 0",
               wr_total - s_wr, evt_log.size() - s_evt, start_log.size() - s_st, oBusy);
    end
    iMu0 = 18'd42; iReq0 = 1'b1;
    wait_start(ok);
    iReq0 = 1'b0;
    step();
    run_words(NW, 1'b1);
    step();
    step();
    vectors++;
    if (wr_total - s_wr != 100 + NW || wr_bad != s_bad || evt_log.size() != s_evt + 1 || evt_log[s_evt] != 0) begin
      miscompares++;
      $display("FAIL midrst_recover: got writes=%0d bad=%0d events=%0d, expected %0d 0 one done0",
               wr_total - s_wr, wr_bad - s_bad, evt_log.size() - s_evt, 100 + NW);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_fairness();
    test_short_run();
    test_hung_engine();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
